// File: rtl/bpm_avg_engine.sv
// Moving-average BPM engine: keeps a ring buffer of recent beat intervals and turns
// their running sum into BPM with a sequential restoring divider.
module bpm_avg_engine #(
    parameter int CNT_W     = 8,
    parameter int BPM_W     = 8,
    parameter int DEPTH     = 4,
    parameter int SAMPLE_HZ = 32,
    parameter int MIN_INT   = 8,
    parameter int MAX_INT   = 96
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [CNT_W-1:0]         interval_in,
    input  logic                     interval_valid,
    output logic [BPM_W-1:0]         bpm_value,
    output logic                     bpm_valid,
    input  logic                     bpm_copied,
    output logic                     bpm_overrun,
    output logic                     interval_reject,
    output logic [$clog2(DEPTH):0]   fill_cnt
);

    localparam int PTR_W        = $clog2(DEPTH);
    localparam int FILL_W       = PTR_W + 1;
    localparam int SUM_W        = CNT_W + PTR_W;
    localparam int BPM_PER_BEAT = 60 * SAMPLE_HZ;
    localparam int QW           = $clog2(BPM_PER_BEAT * DEPTH + 1);
    localparam int STEP_W       = $clog2(QW);
    localparam int BPM_MAX      = (1 << BPM_W) - 1;

    localparam logic [CNT_W-1:0]  MIN_V = CNT_W'(MIN_INT);
    localparam logic [CNT_W-1:0]  MAX_V = CNT_W'(MAX_INT);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(DEPTH);
    localparam logic [QW-1:0]     K_Q   = QW'(BPM_PER_BEAT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [CNT_W-1:0]  ring [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  evicted;
    logic              in_range;
    logic              accept;
    logic              reject;

    logic [1:0]        state;
    logic              pending;
    logic [SUM_W-1:0]  den;
    logic [SUM_W-1:0]  rem;
    logic [QW-1:0]     quo;
    logic [STEP_W-1:0] step;
    logic [SUM_W:0]    rem_sh;
    logic              fits;
    logic [QW-1:0]     numer;
    logic [BPM_W-1:0]  sat_q;
    logic              done_fire;
    logic              copy_now;

    assign in_range  = (interval_in >= MIN_V) && (interval_in <= MAX_V);
    assign accept    = en && interval_valid && in_range;
    assign reject    = en && interval_valid && !in_range;
    assign evicted   = (fill_cnt == FULL) ? ring[wr_ptr] : '0;

    // Numerator is BPM_PER_BEAT scaled by the number of beats in the window.
    assign numer     = K_Q * QW'(fill_cnt);
    assign rem_sh    = {rem, quo[QW-1]};
    assign fits      = rem_sh >= {1'b0, den};
    assign sat_q     = (quo > QW'(BPM_MAX)) ? '1 : quo[BPM_W-1:0];
    assign done_fire = en && (state == S_DONE);
    assign copy_now  = bpm_copied && bpm_valid;

    // NOTE: the ring buffer is cleared on reset so a freshly reset block never
    // reports stale beats; this is a small register file, not an SRAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
            wr_ptr          <= '0;
            sum             <= '0;
            fill_cnt        <= '0;
            interval_reject <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            interval_reject <= reject;
            if (accept) begin
                ring[wr_ptr] <= interval_in;
                wr_ptr       <= wr_ptr + PTR_W'(1);
                sum          <= sum + SUM_W'(interval_in) - SUM_W'(evicted);
                if (fill_cnt != FULL) fill_cnt <= fill_cnt + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pending     <= 1'b0;
            den         <= '0;
            rem         <= '0;
            quo         <= '0;
            step        <= '0;
            bpm_value   <= '0;
            bpm_valid   <= 1'b0;
            bpm_overrun <= 1'b0;
        end else begin
            if (en) begin
                case (state)
                    S_IDLE: begin
                        // LOAD is one edge away, so it already sees a same-edge accept.
                        if (pending) begin
                            state   <= S_LOAD;
                            pending <= 1'b0;
                        end else if (accept) begin
                            pending <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        den   <= sum;
                        rem   <= '0;
                        quo   <= numer;
                        step  <= STEP_W'(QW - 1);
                        state <= S_DIV;
                        if (accept) pending <= 1'b1;
                    end
                    S_DIV: begin
                        rem <= fits ? SUM_W'(rem_sh - {1'b0, den}) : rem_sh[SUM_W-1:0];
                        quo <= {quo[QW-2:0], fits};
                        if (step == '0) state <= S_DONE;
                        else            step  <= step - STEP_W'(1);
                        if (accept) pending <= 1'b1;
                    end
                    default: begin
                        if (pending || accept) begin
                            state   <= S_LOAD;
                            pending <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                endcase
            end

            // A copy on the same edge as a new result acknowledges the old one.
            if (done_fire) begin
                bpm_value <= sat_q;
                bpm_valid <= 1'b1;
                if (copy_now)       bpm_overrun <= 1'b0;
                else if (bpm_valid) bpm_overrun <= 1'b1;
            end else if (copy_now) begin
                bpm_valid   <= 1'b0;
                bpm_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bpm_avg_engine.sv
// Self-checking bench for bpm_avg_engine: vector table, randomized intervals against
// a queue-based window model, and hand-written handshake / timing corner cases.
module tb_bpm_avg_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] interval_in;
    logic       interval_valid;
    logic [7:0] bpm_value;
    logic       bpm_valid;
    logic       bpm_copied;
    logic       bpm_overrun;
    logic       interval_reject;
    logic [2:0] fill_cnt;

    bpm_avg_engine dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .interval_in     (interval_in),
        .interval_valid  (interval_valid),
        .bpm_value       (bpm_value),
        .bpm_valid       (bpm_valid),
        .bpm_copied      (bpm_copied),
        .bpm_overrun     (bpm_overrun),
        .interval_reject (interval_reject),
        .fill_cnt        (fill_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int iv;
        bit rej;
        int bpm;
        int fill;
    } vec_t;

    vec_t vecs [12];
    int   win [$];

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int iv);
        interval_in    = 8'(iv);
        interval_valid = 1'b1;
        step();
        interval_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bpm_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic copy();
        bpm_copied = 1'b1;
        step();
        bpm_copied = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        win.delete();
    endtask

    function automatic bit out_of_range(input int iv);
        return (iv < 8) || (iv > 96);
    endfunction

    function automatic int model_bpm();
        int s = 0;
        int r;
        foreach (win[i]) s += win[i];
        r = (1920 * win.size()) / s;
        return (r > 255) ? 255 : r;
    endfunction

    // Applies one interval from an idle engine and checks the outcome.
    task automatic apply(input string tag, input int iv, input bit rej, input int bpm, input int fill);
        int lat;
        strobe(iv);
        if (rej) begin
            check({tag, " reject pulse"}, int'(interval_reject), 1);
            step();
            check({tag, " reject clears"}, int'(interval_reject), 0);
            repeat (20) step();
            check({tag, " reject no valid"}, int'(bpm_valid), 0);
            check({tag, " reject fill"}, int'(fill_cnt), fill);
        end else begin
            check({tag, " no reject"}, int'(interval_reject), 0);
            wait_valid(lat);
            check({tag, " latency"}, lat, 16);
            check({tag, " bpm"}, int'(bpm_value), bpm);
            check({tag, " fill"}, int'(fill_cnt), fill);
            copy();
            check({tag, " copy clears valid"}, int'(bpm_valid), 0);
        end
    endtask

    initial begin
        int lat;
        int iv;
        bit rej;

        vecs[0]  = '{32,  1'b0, 60,  1};
        vecs[1]  = '{32,  1'b0, 60,  2};
        vecs[2]  = '{16,  1'b0, 72,  3};
        vecs[3]  = '{16,  1'b0, 80,  4};
        vecs[4]  = '{16,  1'b0, 96,  4};
        vecs[5]  = '{5,   1'b1, 0,   4};
        vecs[6]  = '{100, 1'b1, 0,   4};
        vecs[7]  = '{8,   1'b0, 137, 4};
        vecs[8]  = '{7,   1'b1, 0,   4};
        vecs[9]  = '{96,  1'b0, 56,  4};
        vecs[10] = '{97,  1'b1, 0,   4};
        vecs[11] = '{255, 1'b1, 0,   4};

        rst_n          = 1'b1;
        en             = 1'b1;
        interval_in    = '0;
        interval_valid = 1'b0;
        bpm_copied     = 1'b0;
        #2;
        do_reset();
        check("reset bpm_value", int'(bpm_value), 0);
        check("reset bpm_valid", int'(bpm_valid), 0);
        check("reset overrun", int'(bpm_overrun), 0);
        check("reset reject", int'(interval_reject), 0);
        check("reset fill", int'(fill_cnt), 0);

        for (int i = 0; i < 12; i++)
            apply($sformatf("vec%0d", i), vecs[i].iv, vecs[i].rej, vecs[i].bpm, vecs[i].fill);

        do_reset();
        for (int i = 0; i < 25; i++) begin
            iv  = int'($urandom_range(0, 120));
            rej = out_of_range(iv);
            if (!rej) begin
                win.push_back(iv);
                if (win.size() > 4) void'(win.pop_front());
            end
            apply($sformatf("rand%0d iv=%0d", i, iv), iv, rej, rej ? 0 : model_bpm(), win.size());
        end

        // Overwrite without copy, then a copy landing on the DONE edge.
        do_reset();
        strobe(32);
        wait_valid(lat);
        check("ovr first bpm", int'(bpm_value), 60);
        strobe(16);
        repeat (15) step();
        check("ovr before done", int'(bpm_overrun), 0);
        check("ovr old value held", int'(bpm_value), 60);
        step();
        check("ovr new value", int'(bpm_value), 80);
        check("ovr valid held", int'(bpm_valid), 1);
        check("ovr flag set", int'(bpm_overrun), 1);
        strobe(64);
        repeat (15) step();
        bpm_copied = 1'b1;
        step();
        bpm_copied = 1'b0;
        check("samecyc value", int'(bpm_value), 51);
        check("samecyc valid", int'(bpm_valid), 1);
        check("samecyc overrun", int'(bpm_overrun), 0);
        copy();
        check("final copy valid", int'(bpm_valid), 0);
        check("final copy overrun", int'(bpm_overrun), 0);

        // Second interval mid-division collapses to exactly one recomputation.
        do_reset();
        strobe(32);
        repeat (3) step();
        strobe(16);
        repeat (11) step();
        check("collapse pass1 not yet", int'(bpm_valid), 0);
        step();
        check("collapse pass1 valid", int'(bpm_valid), 1);
        check("collapse pass1 bpm", int'(bpm_value), 60);
        copy();
        check("collapse copy", int'(bpm_valid), 0);
        repeat (13) step();
        check("collapse pass2 not yet", int'(bpm_valid), 0);
        step();
        check("collapse pass2 valid", int'(bpm_valid), 1);
        check("collapse pass2 bpm", int'(bpm_value), 80);
        check("collapse fill", int'(fill_cnt), 2);
        repeat (20) step();
        check("collapse no third pass", int'(bpm_overrun), 0);
        check("collapse value stable", int'(bpm_value), 80);

        // Asynchronous reset in the middle of a division.
        strobe(32);
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        check("async rst bpm_value", int'(bpm_value), 0);
        check("async rst valid", int'(bpm_valid), 0);
        check("async rst fill", int'(fill_cnt), 0);
        check("async rst overrun", int'(bpm_overrun), 0);
        step();
        rst_n = 1'b1;
        repeat (30) step();
        check("division discarded", int'(bpm_valid), 0);

        // Enable gating: freeze mid-computation, copy while disabled, strobe ignored.
        strobe(32);
        repeat (3) step();
        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
        wait_valid(lat);
        check("freeze latency", lat, 13);
        check("freeze bpm", int'(bpm_value), 60);
        en = 1'b0;
        copy();
        check("copy while disabled", int'(bpm_valid), 0);
        strobe(32);
        repeat (20) step();
        check("disabled strobe fill", int'(fill_cnt), 1);
        check("disabled strobe valid", int'(bpm_valid), 0);
        en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bpm_avg_engine.md
Name: bpm_avg_engine

Overview:
- Successor to the single-interval BPM stage of DigitalBlock.
- Accepts beat-to-beat intervals, measured in samples, from the peak/interval timer.
- Keeps a DEPTH-entry ring buffer of the most recent valid intervals and converts their running sum to a moving-average BPM with a sequential restoring divider.
- Presents the result on the existing bpm_value/bpm_valid/bpm_copied readout handshake, extended with overrun and out-of-range reporting.

Parameters:
- CNT_W, 8: width of interval_in, in samples.
- BPM_W, 8: width of bpm_value.
- DEPTH, 4: averaging window in beats; power of two, 2..16.
- SAMPLE_HZ, 32: PPG sample rate in Hz.
- MIN_INT, 8: smallest accepted interval in samples (240 BPM at default).
- MAX_INT, 96: largest accepted interval in samples (20 BPM at default).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  block enable
- interval_in  in  CNT_W  beat interval in samples
- interval_valid  in  1  one-cycle strobe qualifying interval_in
- bpm_value  out  BPM_W  averaged BPM, truncated, saturated to 2^BPM_W-1
- bpm_valid  out  1  result available; held until copied
- bpm_copied  in  1  consumer has read bpm_value
- bpm_overrun  out  1  sticky: an unread result was overwritten
- interval_reject  out  1  one-cycle pulse: interval outside [MIN_INT, MAX_INT]
- fill_cnt  out  clog2(DEPTH)+1  number of valid buffer entries, 0..DEPTH

Behaviour:
- Reset (rst_n=0, async): ring buffer, write pointer, sum, fill_cnt, bpm_value, bpm_valid, bpm_overrun, interval_reject and the FSM all clear to 0/IDLE immediately. Reset mid-division discards the division.
- en=0: interval_valid is ignored, the FSM and divider freeze, and all outputs hold. bpm_copied is still honoured.
- Interval accept, at the edge sampling interval_valid=1 with en=1:
  - If interval_in < MIN_INT or > MAX_INT: pulse interval_reject for the next cycle; buffer unchanged.
  - Otherwise: write to buffer[wr_ptr]; sum <= sum + interval_in − evicted entry (evicted = 0 while fill_cnt < DEPTH); wr_ptr wraps modulo DEPTH; fill_cnt saturates at DEPTH.
  - sum width is CNT_W+clog2(DEPTH); it cannot overflow.
- Computation: BPM = floor(60·SAMPLE_HZ·fill_cnt / sum). The numerator is a constant product selected by fill_cnt. QW = clog2(60·SAMPLE_HZ·DEPTH+1), which is 13 at defaults.
- FSM:
  - IDLE: go to LOAD on an accepted interval.
  - LOAD: latch numerator and sum into divider registers; go to DIV.
  - DIV: one quotient bit per cycle for QW cycles; go to DONE.
  - DONE: register the saturated quotient into bpm_value and set bpm_valid; go to IDLE, or to LOAD if an interval was accepted during LOAD/DIV/DONE (pending flag).
- Latency: bpm_valid rises exactly QW+3 edges after the edge accepting the interval (16 at defaults), provided en stays 1.
- Intervals accepted while busy update the buffer immediately. They set pending, so the recomputation uses the latest sum. Multiple intervals arriving while busy collapse to one recomputation.
- Handshake:
  - bpm_copied=1 with bpm_valid=1 clears bpm_valid and bpm_overrun on the next edge.
  - bpm_copied while bpm_valid=0 has no effect.
  - bpm_value stays stable while bpm_valid=1 unless overwritten.
- Overwrite: DONE while bpm_valid=1 and no copy that cycle → new value loaded, bpm_valid stays 1, bpm_overrun set.
- Simultaneous DONE and copy: the new value is loaded, bpm_valid stays 1, and bpm_overrun is cleared, not set.
- Saturation: a quotient above 2^BPM_W-1 outputs 2^BPM_W-1. A divide by zero is impossible because accepted intervals are ≥ MIN_INT ≥ 1.

Test Plan:
- Reset, then a single interval 32 → bpm_valid high 16 cycles later, bpm_value=60, fill_cnt=1. Assert bpm_copied for one cycle → bpm_valid=0 next edge.
- Intervals 32,32,16,16 spaced 40 cycles, each copied → outputs 60,60,72,80; fill_cnt reaches 4. A fifth interval of 16 evicts 32 → sum 80, bpm_value=96.
- Interval 5 and interval 100 → interval_reject pulses once each; fill_cnt, sum and bpm_valid unchanged.
- Two results with no copy in between → second value shown, bpm_overrun=1. A copy in the same cycle as DONE → bpm_overrun stays 0. The next copy clears both flags.
- Intervals 32 then 16 four cycles apart (second arrives mid-DIV) → exactly one extra recomputation. Final bpm_value=80 (fill 2, sum 48), valid at DONE of the second pass.
- Assert rst_n=0 mid-DIV → all outputs 0 immediately. Hold en=0 during an interval strobe → ignored and fill_cnt unchanged.
